// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit engine states and the bit-period divider.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Bus clock cycles per serial bit (integer division).
    function automatic int div_count(input int bus_clk, input int baud);
        return bus_clk / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; frames go back to back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BUS_CLK    = 40_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dout,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int            DIV      = div_count(BUS_CLK, BAUD);
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    tx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          pop, full, empty, tick;
    logic [7:0]    fifo_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (send),
        .pop   (pop),
        .din   (dout),
        .dout  (fifo_data),
        .full  (full),
        .empty (empty)
    );

    assign ready = !full;
    assign tx    = tx_q;
    assign done  = done_q;
    assign busy  = (state_q != TX_IDLE) || !empty;
    assign tick  = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                div_d = '0;
                tx_d  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            // The shifter always presents the next data bit in bit 0.
            TX_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    done_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule
